// File: rtl/mls_pkg.sv
// Shared types and defaults for the multi-lane 64b66b-style scrambler.
package mls_pkg;

    typedef enum logic {
        MLS_SCRAMBLE   = 1'b0,
        MLS_DESCRAMBLE = 1'b1
    } mls_mode_e;

    localparam int unsigned MLS_DEF_TAP_A      = 38;
    localparam int unsigned MLS_DEF_TAP_B      = 57;
    localparam int unsigned MLS_DEF_LFSR_WIDTH = 58;

    // Width of a counter that must reach lfsr_width inclusive.
    function automatic int unsigned mls_cnt_width(input int unsigned lfsr_width);
        return $clog2(lfsr_width + 1);
    endfunction

endpackage

// File: rtl/mls_lane.sv
// One lane: self-synchronous LFSR state, unrolled per-beat step, lock counter.
module mls_lane
    import mls_pkg::*;
#(
    parameter int unsigned           LANE_WIDTH = 64,
    parameter int unsigned           LFSR_WIDTH = MLS_DEF_LFSR_WIDTH,
    parameter int unsigned           TAP_A      = MLS_DEF_TAP_A,
    parameter int unsigned           TAP_B      = MLS_DEF_TAP_B,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1,
    parameter mls_mode_e             MODE       = MLS_SCRAMBLE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  advance,
    input  logic                  resync,
    input  logic [LANE_WIDTH-1:0] din,
    output logic [LANE_WIDTH-1:0] dout_c,
    output logic                  lock
);

    localparam int unsigned       CNT_W   = mls_cnt_width(LFSR_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LFSR_WIDTH);

    logic [LFSR_WIDTH-1:0] state_q, state_d, state_step;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lock_q, lock_d;

    // Bit-serial scrambler unrolled over the beat; bit 0 is processed first.
    always_comb begin
        logic [LFSR_WIDTH-1:0] s;
        logic                  fb;
        logic                  obit;
        s      = state_q;
        fb     = 1'b0;
        obit   = 1'b0;
        dout_c = '0;
        for (int i = 0; i < int'(LANE_WIDTH); i++) begin
            fb        = s[TAP_A] ^ s[TAP_B];
            obit      = din[i] ^ fb;
            dout_c[i] = obit;
            s         = {s[LFSR_WIDTH-2:0], (MODE == MLS_DESCRAMBLE) ? din[i] : obit};
        end
        state_step = s;
    end

    // Next state: resync wins over an accepted beat; counter saturates at LFSR_WIDTH.
    always_comb begin
        logic [31:0] sum;
        state_d = state_q;
        cnt_d   = cnt_q;
        sum     = 32'(cnt_q) + 32'(LANE_WIDTH);
        if (resync) begin
            state_d = LFSR_INIT;
            cnt_d   = '0;
        end else if (advance) begin
            state_d = state_step;
            cnt_d   = (sum >= 32'(LFSR_WIDTH)) ? CNT_MAX : CNT_W'(sum);
        end
        lock_d = (MODE == MLS_DESCRAMBLE) && (cnt_d == CNT_MAX);
    end

    // Lane state, counter and lock registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LFSR_INIT;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
        end
    end

    assign lock = lock_q;

endmodule

// File: rtl/multi_lane_scrambler.sv
// Multi-lane self-synchronous scrambler/descrambler with one registered output stage.
module multi_lane_scrambler
    import mls_pkg::*;
#(
    parameter int unsigned           NUM_LANES  = 4,
    parameter int unsigned           LANE_WIDTH = 64,
    parameter int unsigned           LFSR_WIDTH = MLS_DEF_LFSR_WIDTH,
    parameter int unsigned           TAP_A      = MLS_DEF_TAP_A,
    parameter int unsigned           TAP_B      = MLS_DEF_TAP_B,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1,
    parameter string                 MODE       = "SCRAMBLE"
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    input  logic [NUM_LANES-1:0]            lane_bypass,
    input  logic [NUM_LANES-1:0]            lane_resync,
    output logic [NUM_LANES-1:0]            lane_lock
);

    localparam int unsigned DATA_W = NUM_LANES * LANE_WIDTH;
    localparam mls_mode_e   MODE_E = (MODE == "DESCRAMBLE") ? MLS_DESCRAMBLE : MLS_SCRAMBLE;

    logic [DATA_W-1:0]    m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic [DATA_W-1:0]    lane_out_c;
    logic [DATA_W-1:0]    beat_c;
    logic [NUM_LANES-1:0] lane_adv_c;
    logic                 accept_c;

    // Output stage is free when empty or being drained this cycle.
    assign s_ready    = !m_valid_q || m_ready;
    assign accept_c   = s_valid && s_ready;
    assign lane_adv_c = {NUM_LANES{accept_c}} & ~lane_bypass;

    // Independent lanes; bypassed lanes pass input straight through.
    for (genvar k = 0; k < int'(NUM_LANES); k++) begin : g_lane
        mls_lane #(
            .LANE_WIDTH (LANE_WIDTH),
            .LFSR_WIDTH (LFSR_WIDTH),
            .TAP_A      (TAP_A),
            .TAP_B      (TAP_B),
            .LFSR_INIT  (LFSR_INIT),
            .MODE       (MODE_E)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (lane_adv_c[k]),
            .resync  (lane_resync[k]),
            .din     (s_data[k*LANE_WIDTH +: LANE_WIDTH]),
            .dout_c  (lane_out_c[k*LANE_WIDTH +: LANE_WIDTH]),
            .lock    (lane_lock[k])
        );

        assign beat_c[k*LANE_WIDTH +: LANE_WIDTH] = lane_bypass[k]
            ? s_data[k*LANE_WIDTH +: LANE_WIDTH]
            : lane_out_c[k*LANE_WIDTH +: LANE_WIDTH];
    end

    // Output stage load/drain; data holds while stalled.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (accept_c) begin
            m_valid_d = 1'b1;
            m_data_d  = beat_c;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output registers; reset drops any pending beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule
